// File: rtl/regfile_pkg.sv
// regfile_pkg: values shared by the register file and the branch unit.
//   DATA_W_DEF / NUM_REGS_DEF : default register width and register count
//   CC_N / CC_Z / CC_P        : one-hot {N,Z,P} condition codes (CC_Z is the reset value)
//   nzp_of                    : condition code of a value, given its sign bit and zero flag
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Takes the sign bit and an is-zero flag rather than the whole word so
    // that callers of any data width can share it.
    function automatic logic [2:0] nzp_of(input logic sign, input logic zero);
        return {sign, zero, !sign && !zero};
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for the pipelined register file.
//   clk, reset          : clock, synchronous active-high reset
//   iss_en, iss_dr      : issue strobe / destination, sets the busy bit
//   wr_en, wr_addr      : writeback strobe / destination, clears the busy bit
//   sr1, sr2            : operand indices being decoded
//   busy_vec            : registered busy bits, bit i is register i
//   sr1_busy, sr2_busy  : operand still pending (a same-cycle writeback releases it)
module regfile_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_dr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [ADDR_W-1:0]   sr1,
    input  logic [ADDR_W-1:0]   sr2,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                sr1_busy,
    output logic                sr2_busy
);

    logic [NUM_REGS-1:0] busy_next;

    // Issue has priority over writeback so a back-to-back producer of the
    // same register keeps the bit set while the older result retires.
    always_comb begin
        busy_next = busy_vec;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (iss_en && iss_dr == ADDR_W'(i))
                busy_next[i] = 1'b1;
            else if (wr_en && wr_addr == ADDR_W'(i))
                busy_next[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy_vec <= '0;
        else
            busy_vec <= busy_next;
    end

    // Same-cycle issue is deliberately ignored here: an instruction must not
    // stall on its own destination.
    assign sr1_busy = busy_vec[sr1] && !(wr_en && wr_addr == sr1);
    assign sr2_busy = busy_vec[sr2] && !(wr_en && wr_addr == sr2);

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with write-to-read bypass,
// busy scoreboard and NZP condition codes.
//   clk, reset              : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data : writeback port
//   ld_cc                   : load NZP from wr_data (only with wr_en)
//   iss_en, iss_dr          : issue port, marks destination busy
//   sr1, sr2                : read indices
//   rd_data1, rd_data2      : combinational read data, bypassed from writeback
//   sr1_busy, sr2_busy      : operand not yet available
//   busy_vec                : registered scoreboard
//   nzp                     : registered {N,Z,P}
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                ld_cc,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_dr,
    input  logic [ADDR_W-1:0]   sr1,
    input  logic [ADDR_W-1:0]   sr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                sr1_busy,
    output logic                sr2_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [2:0]          nzp
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
            nzp <= CC_Z;
        end else begin
            if (wr_en)
                mem[wr_addr] <= wr_data;
            if (wr_en && ld_cc)
                nzp <= nzp_of(wr_data[DATA_W-1], wr_data == '0);
        end
    end

    // NUM_REGS is a power of two, so every index value addresses a register.
    assign rd_data1 = (wr_en && wr_addr == sr1) ? wr_data : mem[sr1];
    assign rd_data2 = (wr_en && wr_addr == sr2) ? wr_data : mem[sr2];

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_dr   (iss_dr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .sr1      (sr1),
        .sr2      (sr2),
        .busy_vec (busy_vec),
        .sr1_busy (sr1_busy),
        .sr2_busy (sr2_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default 8 x 16 instance
    logic        reset, wr_en, ld_cc, iss_en;
    logic [2:0]  wr_addr, iss_dr, sr1, sr2;
    logic [15:0] wr_data, rd_data1, rd_data2;
    logic        sr1_busy, sr2_busy;
    logic [7:0]  busy_vec;
    logic [2:0]  nzp;

    regfile_sb dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_cc(ld_cc), .iss_en(iss_en), .iss_dr(iss_dr), .sr1(sr1), .sr2(sr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
        .busy_vec(busy_vec), .nzp(nzp)
    );

    // 16 x 32 instance
    logic        b_reset, b_wr_en, b_ld_cc, b_iss_en;
    logic [3:0]  b_wr_addr, b_iss_dr, b_sr1, b_sr2;
    logic [31:0] b_wr_data, b_rd_data1, b_rd_data2;
    logic        b_sr1_busy, b_sr2_busy;
    logic [15:0] b_busy_vec;
    logic [2:0]  b_nzp;

    regfile_sb #(.DATA_W(32), .NUM_REGS(16)) dut_b (
        .clk(clk), .reset(b_reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .ld_cc(b_ld_cc), .iss_en(b_iss_en), .iss_dr(b_iss_dr), .sr1(b_sr1), .sr2(b_sr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2), .sr1_busy(b_sr1_busy), .sr2_busy(b_sr2_busy),
        .busy_vec(b_busy_vec), .nzp(b_nzp)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        lc, ie;
        logic [2:0]  dr, s1, s2;
        logic        chk;
        logic [15:0] e_rd1, e_rd2;
        logic        e_b1, e_b2;
        logic [7:0]  e_busy;
        logic [2:0]  e_nzp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic rst, we, input logic [2:0] wa, input logic [15:0] wd,
        input logic lc, ie, input logic [2:0] dr, s1, s2,
        input logic chk, input logic [15:0] e_rd1, e_rd2, input logic e_b1, e_b2,
        input logic [7:0] e_busy, input logic [2:0] e_nzp);
        vec_t r;
        r.rst = rst; r.we = we; r.wa = wa; r.wd = wd; r.lc = lc; r.ie = ie;
        r.dr = dr; r.s1 = s1; r.s2 = s2; r.chk = chk;
        r.e_rd1 = e_rd1; r.e_rd2 = e_rd2; r.e_b1 = e_b1; r.e_b2 = e_b2;
        r.e_busy = e_busy; r.e_nzp = e_nzp;
        return r;
    endfunction

    task automatic drive(input logic rst, we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic lc, ie, input logic [2:0] dr, s1, s2);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        ld_cc = lc; iss_en = ie; iss_dr = dr; sr1 = s1; sr2 = s2;
    endtask

    // Reference model: plain architectural state
    logic [15:0] m_reg [8];
    logic        m_busy [8];
    logic [2:0]  m_nzp;

    function automatic logic [2:0] cc_of(input logic [15:0] d);
        if (d[15])       return 3'b100;
        else if (d == 0) return 3'b010;
        else             return 3'b001;
    endfunction

    initial begin
        logic rst, we, lc, ie;
        logic [2:0] wa, dr, s1, s2;
        logic [15:0] wd, er1, er2;
        logic [7:0] ebusy;
        logic eb1, eb2;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_reset = 1; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_ld_cc = 0;
        b_iss_en = 0; b_iss_dr = 0; b_sr1 = 0; b_sr2 = 0;

        //           rst we wa wd        lc ie dr s1 s2 chk rd1       rd2       b1 b2 busy       nzp
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 1, 3, 16'h1234, 0, 0, 0, 3, 0, 1, 16'h1234, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 1, 16'h1234, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 1, 5, 16'hBEEF, 0, 0, 0, 5, 3, 1, 16'hBEEF, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 5, 3, 1, 16'hBEEF, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 1, 1, 16'h8000, 1, 0, 0, 1, 5, 1, 16'h8000, 16'hBEEF, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 1, 1, 16'h0000, 1, 0, 0, 1, 5, 1, 16'h0000, 16'hBEEF, 0, 0, 8'h00, 3'b100));
        tbl.push_back(v(0, 1, 1, 16'h0007, 1, 0, 0, 1, 5, 1, 16'h0007, 16'hBEEF, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 1, 6, 16'h8001, 0, 0, 0, 1, 5, 1, 16'h0007, 16'hBEEF, 0, 0, 8'h00, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 1, 0, 0, 6, 5, 1, 16'h8001, 16'hBEEF, 0, 0, 8'h00, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 6, 5, 1, 16'h8001, 16'hBEEF, 0, 0, 8'h00, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 1, 2, 0, 2, 1, 16'h0000, 16'h0000, 0, 0, 8'h00, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 0, 2, 1, 16'h0000, 16'h0000, 0, 1, 8'h04, 3'b001));
        tbl.push_back(v(0, 1, 2, 16'hABCD, 0, 0, 0, 2, 2, 1, 16'hABCD, 16'hABCD, 0, 0, 8'h04, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 0, 2, 1, 16'h0000, 16'hABCD, 0, 0, 8'h00, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 1, 4, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h00, 3'b001));
        tbl.push_back(v(0, 1, 4, 16'h4444, 0, 1, 4, 4, 0, 1, 16'h4444, 16'h0000, 0, 0, 8'h10, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 4, 0, 1, 16'h4444, 16'h0000, 1, 0, 8'h10, 3'b001));
        tbl.push_back(v(0, 1, 0, 16'h5A5A, 0, 0, 0, 0, 4, 1, 16'h5A5A, 16'h4444, 0, 1, 8'h10, 3'b001));
        tbl.push_back(v(1, 0, 0, 16'h0000, 0, 1, 7, 0, 4, 1, 16'h5A5A, 16'h4444, 0, 1, 8'h10, 3'b001));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 0, 4, 1, 16'h0000, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 1, 4, 16'h1111, 0, 0, 0, 4, 7, 1, 16'h1111, 16'h0000, 0, 0, 8'h00, 3'b010));
        tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 0, 4, 7, 1, 16'h1111, 16'h0000, 0, 0, 8'h00, 3'b010));

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].lc,
                  tbl[k].ie, tbl[k].dr, tbl[k].s1, tbl[k].s2);
            #1;
            if (tbl[k].chk) begin
                check($sformatf("tbl%0d rd_data1", k), 32'(rd_data1), 32'(tbl[k].e_rd1));
                check($sformatf("tbl%0d rd_data2", k), 32'(rd_data2), 32'(tbl[k].e_rd2));
                check($sformatf("tbl%0d sr1_busy", k), 32'(sr1_busy), 32'(tbl[k].e_b1));
                check($sformatf("tbl%0d sr2_busy", k), 32'(sr2_busy), 32'(tbl[k].e_b2));
                check($sformatf("tbl%0d busy_vec", k), 32'(busy_vec), 32'(tbl[k].e_busy));
                check($sformatf("tbl%0d nzp", k), 32'(nzp), 32'(tbl[k].e_nzp));
            end
        end

        // Randomised run against the architectural model, starting from reset.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
        m_nzp = 3'b010;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            we  = $urandom_range(0, 1);
            wa  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       wd = 16'h0000;
                1:       wd = 16'h8000 | 16'($urandom_range(0, 255));
                default: wd = 16'($urandom);
            endcase
            lc = $urandom_range(0, 1);
            ie = $urandom_range(0, 1);
            dr = 3'($urandom_range(0, 7));
            s1 = 3'($urandom_range(0, 7));
            s2 = 3'($urandom_range(0, 7));
            drive(rst, we, wa, wd, lc, ie, dr, s1, s2);
            #1;

            er1 = (we && wa == s1) ? wd : m_reg[s1];
            er2 = (we && wa == s2) ? wd : m_reg[s2];
            eb1 = m_busy[s1] && !(we && wa == s1);
            eb2 = m_busy[s2] && !(we && wa == s2);
            for (int i = 0; i < 8; i++) ebusy[i] = m_busy[i];
            check($sformatf("rnd%0d rd_data1", n), 32'(rd_data1), 32'(er1));
            check($sformatf("rnd%0d rd_data2", n), 32'(rd_data2), 32'(er2));
            check($sformatf("rnd%0d sr1_busy", n), 32'(sr1_busy), 32'(eb1));
            check($sformatf("rnd%0d sr2_busy", n), 32'(sr2_busy), 32'(eb2));
            check($sformatf("rnd%0d busy_vec", n), 32'(busy_vec), 32'(ebusy));
            check($sformatf("rnd%0d nzp", n), 32'(nzp), 32'(m_nzp));

            // state after the coming edge
            if (rst) begin
                for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
                m_nzp = 3'b010;
            end else begin
                if (we) begin
                    m_reg[wa]  = wd;
                    m_busy[wa] = 1'b0;
                    if (lc) m_nzp = cc_of(wd);
                end
                if (ie) m_busy[dr] = 1'b1;  // issue overrides a same-register writeback
            end
        end

        // Wide/deep instance: 16 x 32.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_reset = 1;
        @(negedge clk);
        b_reset = 0;
        #1;
        check("wide reset nzp", 32'(b_nzp), 32'(3'b010));
        check("wide reset busy_vec", 32'(b_busy_vec), 32'h0);
        @(negedge clk);
        b_wr_en = 1; b_wr_addr = 4'd15; b_wr_data = 32'hFFFF_FFFF; b_ld_cc = 1;
        b_sr1 = 4'd15; b_sr2 = 4'd14; b_iss_en = 1; b_iss_dr = 4'd12;
        #1;
        check("wide bypass rd_data1", b_rd_data1, 32'hFFFF_FFFF);
        check("wide rd_data2", b_rd_data2, 32'h0);
        @(negedge clk);
        b_wr_en = 0; b_ld_cc = 0; b_iss_en = 0; b_sr2 = 4'd12;
        #1;
        check("wide stored rd_data1", b_rd_data1, 32'hFFFF_FFFF);
        check("wide nzp", 32'(b_nzp), 32'(3'b100));
        check("wide busy_vec", 32'(b_busy_vec), 32'h0000_1000);
        check("wide sr2_busy", 32'(b_sr2_busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
